// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared tic-tac-toe constants, select FSM encoding and cell helpers
package ttt_pkg;

  localparam logic [2:0] STATUS_IN_PROGRESS = 3'b000;
  localparam int         IDX_W              = 4;
  localparam int         BOARD_W            = 9;
  localparam logic [IDX_W-1:0] CENTER_CELL  = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sel_state_e;

  function automatic logic [BOARD_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [BOARD_W-1:0] oh;
    oh = '0;
    if (idx < IDX_W'(BOARD_W)) oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/move_entry_if.sv
// rtl/move_entry_if.sv - buttons, board readback and move request bundle
interface move_entry_if;
  import ttt_pkg::*;

  logic               btn_up;
  logic               btn_down;
  logic               btn_left;
  logic               btn_right;
  logic               btn_select;
  logic [BOARD_W-1:0] X_state;
  logic [BOARD_W-1:0] O_state;
  logic [2:0]         GameStatus;
  logic               move;
  logic [IDX_W-1:0]   nextMove;
  logic [BOARD_W-1:0] cursor;
  logic               cursor_blink;
  logic               reject;

  modport master (
    input  btn_up, btn_down, btn_left, btn_right, btn_select,
    input  X_state, O_state, GameStatus,
    output move, nextMove, cursor, cursor_blink, reject
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right, btn_select,
    output X_state, O_state, GameStatus,
    input  move, nextMove, cursor, cursor_blink, reject
  );

endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop sync, level debounce and one-cycle press event
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic             press_q, press_d;
  logic             armed_q, armed_d;
  logic [1:0]       fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = '0;
    // Arm only once the refilled synchronizer has seen the button released,
    // so a button held through reset never produces a press.
    fill_d       = {fill_q[0], 1'b1};
    armed_d      = armed_q | (fill_q[1] & ~sync2_q);
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = sync2_q;
      else                  cnt_d    = cnt_q + CNT_W'(1);
    end
    press_d = stable_q & ~stable_dly_q & armed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
      armed_q      <= 1'b0;
      fill_q       <= '0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      press_q      <= press_d;
      armed_q      <= armed_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/move_entry.sv
// rtl/move_entry.sv - button-driven 3x3 cursor and move request producer for the game-state block
module move_entry
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 25000000,
  parameter int WAIT_CYCLES     = 15
) (
  input  logic         clk,
  input  logic         rst,
  move_entry_if.master bus
);

  localparam int                 BLINK_W   = $clog2(BLINK_CYCLES + 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);
  localparam int                 WAIT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(WAIT_CYCLES - 1);

  logic ev_up, ev_down, ev_left, ev_right, ev_sel;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_up), .press(ev_up));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_down), .press(ev_down));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_left), .press(ev_left));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_right), .press(ev_right));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_select (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_select), .press(ev_sel));

  sel_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BOARD_W-1:0] cursor_q, cursor_d;
  logic [IDX_W-1:0]   next_move_q, next_move_d;
  logic               move_q, move_d;
  logic               reject_q, reject_d;
  logic               blink_q, blink_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BOARD_W-1:0] occupied;
  logic               in_progress;

  assign occupied    = bus.X_state | bus.O_state;
  assign in_progress = (bus.GameStatus == STATUS_IN_PROGRESS);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    next_move_d = next_move_q;
    move_d      = 1'b0;
    reject_d    = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;

    // Select outranks navigation even when the FSM is busy and drops it.
    if (!ev_sel) begin
      if (ev_up)         idx_d = (idx_q < 4'd3) ? idx_q + 4'd6 : idx_q - 4'd3;
      else if (ev_down)  idx_d = (idx_q > 4'd5) ? idx_q - 4'd6 : idx_q + 4'd3;
      else if (ev_left)  idx_d = (idx_q % 4'd3 == 4'd0) ? idx_q + 4'd2 : idx_q - 4'd1;
      else if (ev_right) idx_d = (idx_q % 4'd3 == 4'd2) ? idx_q - 4'd2 : idx_q + 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ev_sel) begin
          if (!occupied[idx_q] && in_progress) begin
            state_d     = ST_ISSUE;
            next_move_d = idx_q;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        move_d     = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (occupied[next_move_q] || !in_progress || wait_cnt_q == WAIT_MAX)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cursor_d = idx_to_onehot(idx_d);
    if (idx_d != idx_q) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= CENTER_CELL;
      cursor_q    <= idx_to_onehot(CENTER_CELL);
      next_move_q <= CENTER_CELL;
      move_q      <= 1'b0;
      reject_q    <= 1'b0;
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cursor_q    <= cursor_d;
      next_move_q <= next_move_d;
      move_q      <= move_d;
      reject_q    <= reject_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.move         = move_q;
  assign bus.nextMove     = next_move_q;
  assign bus.cursor       = cursor_q;
  assign bus.cursor_blink = blink_q;
  assign bus.reject       = reject_q;

endmodule
